// File: rtl/activation_pack_pkg.sv
// activation_pack_pkg: shared neural-network definitions for the activation
// packing slice. Holds the default activation width and pack factor, the
// matching saturation bounds, and helpers that derive the bounds for any
// output width.
package activation_pack_pkg;

  function automatic int sat_max(input int unsigned width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned width);
    return -(1 << (width - 1));
  endfunction

  localparam int unsigned ACT_OUTPUT_BITWIDTH = 8;
  localparam int unsigned ACT_LOG2_PACK       = 3;
  localparam int          ACT_SAT_MAX         = sat_max(ACT_OUTPUT_BITWIDTH);
  localparam int          ACT_SAT_MIN         = sat_min(ACT_OUTPUT_BITWIDTH);

endpackage

// File: rtl/activation_fifo.sv
// activation_fifo: small synchronous FIFO of packed output words. Each slot
// holds {last, keep, data}. A push into a full FIFO succeeds only when a pop
// happens in the same cycle; otherwise it is dropped and drop_o pulses.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   push_i, data_i,
//   keep_i, last_i         write side (one entry per push)
//   ready_i                consumer ready; pop = valid_o & ready_i
//   valid_o, data_o,
//   keep_o, last_o         head entry, stable until popped
//   drop_o                 push rejected this cycle (FIFO full, no pop)
module activation_fifo #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned KEEP_W     = 8,
  parameter int unsigned LOG2_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [KEEP_W-1:0] keep_o,
  output logic              last_o,
  output logic              drop_o
);

  localparam int unsigned DEPTH   = 1 << LOG2_DEPTH;
  localparam int unsigned ENTRY_W = DATA_W + KEEP_W + 1;

  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [LOG2_DEPTH:0] wr_q, rd_q;
  logic                empty, full, pop, wr_en;
  logic [ENTRY_W-1:0]  head;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[LOG2_DEPTH] != rd_q[LOG2_DEPTH]) &&
                 (wr_q[LOG2_DEPTH-1:0] == rd_q[LOG2_DEPTH-1:0]);
  assign pop    = !empty && ready_i;
  assign wr_en  = push_i && (!full || pop);
  assign drop_o = push_i && full && !pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q[LOG2_DEPTH-1:0]] <= {last_i, keep_i, data_i};
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  assign head    = mem_q[rd_q[LOG2_DEPTH-1:0]];
  assign valid_o = !empty;
  assign data_o  = head[DATA_W-1:0];
  assign keep_o  = head[DATA_W +: KEEP_W];
  assign last_o  = head[ENTRY_W-1];

endmodule

// File: rtl/activation_pack.sv
// activation_pack: requantizes signed integrated values (rounding arithmetic
// right shift + saturation), packs 2**LOG2_PACK activations per output word
// and streams the words out over AXI-Stream through activation_fifo.
// Build option: define ACTIVATION_RELU_EN to clamp negative results to 0.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   s_integration_tdata/tvalid         input values (no back-pressure)
//   shift_amount                       requantization right shift 0..15
//   num_outputs                        values per vector (0 treated as 1)
//   m_axis_tdata/tkeep/tvalid/
//   m_axis_tready/tlast                packed output stream
//   overflow                           sticky: a packed word was dropped
module activation_pack
  import activation_pack_pkg::*;
#(
  parameter int unsigned VALUE_BITWIDTH         = 16,
  parameter int unsigned OUTPUT_BITWIDTH        = ACT_OUTPUT_BITWIDTH,
  parameter int unsigned LOG2_PACK              = ACT_LOG2_PACK,
  parameter int unsigned CYCLE_COUNTER_BITWIDTH = 10,
  parameter int unsigned LOG2_FIFO_DEPTH        = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [VALUE_BITWIDTH-1:0]              s_integration_tdata,
  input  logic                                   s_integration_tvalid,
  input  logic [3:0]                             shift_amount,
  input  logic [CYCLE_COUNTER_BITWIDTH-1:0]      num_outputs,
  output logic [OUTPUT_BITWIDTH*(2**LOG2_PACK)-1:0] m_axis_tdata,
  output logic [(2**LOG2_PACK)-1:0]              m_axis_tkeep,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic                                   m_axis_tlast,
  output logic                                   overflow
);

  localparam int unsigned PACK   = 1 << LOG2_PACK;
  localparam int unsigned WORD_W = OUTPUT_BITWIDTH * PACK;
  localparam int unsigned EXT_W  = VALUE_BITWIDTH + 1;
  localparam int unsigned CNT_W  = CYCLE_COUNTER_BITWIDTH;
  localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(sat_max(OUTPUT_BITWIDTH));
  localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(sat_min(OUTPUT_BITWIDTH));

  // ---------------- stage 1: requantize ----------------
  logic                       q1_valid_q;
  logic [OUTPUT_BITWIDTH-1:0] q1_data_q, q1_data_d;
  logic [CNT_W-1:0]           q1_num_q;
  logic signed [EXT_W-1:0]    ext, rnd, shf;
  logic [EXT_W-1:0]           half;

  always_comb begin
    ext  = {s_integration_tdata[VALUE_BITWIDTH-1], s_integration_tdata};
    half = '0;
    if (shift_amount != 4'd0) half = EXT_W'(1) << (shift_amount - 4'd1);
    rnd = ext + signed'(half);
    shf = rnd >>> shift_amount;
`ifdef ACTIVATION_RELU_EN
    if (shf[EXT_W-1]) shf = '0;
`endif
    if (shf > SAT_HI)      q1_data_d = SAT_HI[OUTPUT_BITWIDTH-1:0];
    else if (shf < SAT_LO) q1_data_d = SAT_LO[OUTPUT_BITWIDTH-1:0];
    else                   q1_data_d = shf[OUTPUT_BITWIDTH-1:0];
  end

  // num_outputs travels with its value so the vector length is the one
  // present when the vector's first value arrived.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_valid_q <= 1'b0;
      q1_data_q  <= '0;
      q1_num_q   <= '0;
    end else begin
      q1_valid_q <= s_integration_tvalid;
      if (s_integration_tvalid) begin
        q1_data_q <= q1_data_d;
        q1_num_q  <= num_outputs;
      end
    end
  end

  // ---------------- stage 2: pack ----------------
  logic [LOG2_PACK-1:0] lane_q, lane_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, num_q, num_d, num_raw, num_eff;
  logic [WORD_W-1:0]    word_q, word_d, word_next;
  logic [PACK-1:0]      keep_next;
  logic                 is_last, complete, push;

  always_comb begin
    num_raw = (cnt_q == '0) ? q1_num_q : num_q;
    num_eff = (num_raw == '0) ? CNT_W'(1) : num_raw;
    word_next = word_q;
    word_next[lane_q*OUTPUT_BITWIDTH +: OUTPUT_BITWIDTH] = q1_data_q;
    for (int unsigned i = 0; i < PACK; i++) keep_next[i] = (i <= 32'(lane_q));
    is_last  = (cnt_q == num_eff - CNT_W'(1));
    complete = (lane_q == '1) || is_last;
    push     = q1_valid_q && complete;

    lane_d = lane_q;
    cnt_d  = cnt_q;
    num_d  = num_q;
    word_d = word_q;
    if (q1_valid_q) begin
      if (cnt_q == '0) num_d = num_eff;
      if (complete) begin
        word_d = '0;
        lane_d = '0;
        cnt_d  = is_last ? '0 : cnt_q + CNT_W'(1);
      end else begin
        word_d = word_next;
        lane_d = lane_q + 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      cnt_q  <= '0;
      num_q  <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      cnt_q  <= cnt_d;
      num_q  <= num_d;
      word_q <= word_d;
    end
  end

  // ---------------- output FIFO ----------------
  logic fifo_drop;

  activation_fifo #(
    .DATA_W    (WORD_W),
    .KEEP_W    (PACK),
    .LOG2_DEPTH(LOG2_FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (push),
    .data_i (word_next),
    .keep_i (keep_next),
    .last_i (is_last),
    .ready_i(m_axis_tready),
    .valid_o(m_axis_tvalid),
    .data_o (m_axis_tdata),
    .keep_o (m_axis_tkeep),
    .last_o (m_axis_tlast),
    .drop_o (fifo_drop)
  );

  logic overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         overflow_q <= 1'b0;
    else if (fifo_drop) overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;

endmodule
